// File: rtl/pwm_multi_avalon_if.sv
// Avalon-MM slave bus bundle for pwm_multi_avalon.
//   avs_address   : word address (4 bits)
//   avs_read      : read strobe
//   avs_write     : write strobe
//   avs_writedata : write data (32 bits)
//   avs_readdata  : read data, valid the cycle after avs_read (32 bits)
interface pwm_multi_avalon_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pwm_multi_avalon.sv
// Multi-channel PWM generator with a shared timebase and an Avalon-MM
// register interface. Period, mode, polarity and duties are double-buffered:
// writes land in staging registers and are copied into the active set on a
// period boundary, on the rising edge of CTRL.en, or on a CTRL.force write.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   avs     : Avalon-MM slave (address/read/write/writedata/readdata)
//   pwm_out : registered PWM outputs, one per channel
//   irq     : registered level interrupt, STATUS.pend & CTRL.irq_en
module pwm_multi_avalon #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pwm_multi_avalon_if.slave avs,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] A_CTRL     = 4'h0;
  localparam logic [ADDR_W-1:0] A_PRESCALE = 4'h1;
  localparam logic [ADDR_W-1:0] A_PERIOD   = 4'h2;
  localparam logic [ADDR_W-1:0] A_POLARITY = 4'h3;
  localparam logic [ADDR_W-1:0] A_STATUS   = 4'h4;
  localparam int unsigned       A_DUTY0    = 8;

  // Staging / control registers
  logic                         ctrl_en;
  logic                         ctrl_mode;
  logic                         ctrl_irq_en;
  logic [PRE_W-1:0]             prescale;
  logic [CNT_W-1:0]             period_stg;
  logic [NUM_CH-1:0]            pol_stg;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_stg;
  logic                         pend;

  // Active set
  logic [CNT_W-1:0]             period_act;
  logic                         mode_act;
  logic [NUM_CH-1:0]            pol_act;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act;

  // Timebase
  logic [PRE_W-1:0]             pre_cnt;
  logic [CNT_W-1:0]             cnt;
  logic                         dir_down;

  // Combinational helpers
  logic                         wr_ctrl;
  logic                         force_wr;
  logic                         en_nxt;
  logic                         en_rise;
  logic                         w1c;
  logic                         tick;
  logic                         bnd_raw;
  logic                         boundary;
  logic                         update;
  logic [PRE_W-1:0]             pre_nxt;
  logic [CNT_W-1:0]             cnt_nxt;
  logic                         dir_nxt;
  logic [NUM_CH-1:0]            raw;
  logic [DATA_W-1:0]            rdata;
  logic                         unused_wdata;

  // No register field is wider than 16 bits.
  assign unused_wdata = ^avs.avs_writedata[DATA_W-1:16];

  // Write decode and update-event sources
  always_comb begin
    wr_ctrl  = avs.avs_write && (avs.avs_address == A_CTRL);
    force_wr = wr_ctrl && avs.avs_writedata[3];
    en_nxt   = wr_ctrl ? avs.avs_writedata[0] : ctrl_en;
    en_rise  = en_nxt && !ctrl_en;
    w1c      = avs.avs_write && (avs.avs_address == A_STATUS) && avs.avs_writedata[0];
    tick     = ctrl_en && (pre_cnt >= prescale);
  end

  // Prescaler and edge/center counter next state
  always_comb begin
    pre_nxt = pre_cnt;
    cnt_nxt = cnt;
    dir_nxt = dir_down;
    bnd_raw = 1'b0;
    if (tick) begin
      pre_nxt = '0;
      if (!mode_act) begin
        if (cnt >= period_act) begin
          cnt_nxt = '0;
          bnd_raw = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (!dir_down && (cnt < period_act)) begin
        cnt_nxt = cnt + 1'b1;
      end else if (cnt <= CNT_W'(1)) begin
        // Bottom of the down slope (also covers PERIOD of 0 or 1).
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        bnd_raw = 1'b1;
      end else begin
        cnt_nxt = cnt - 1'b1;
        dir_nxt = 1'b1;
      end
    end else if (ctrl_en) begin
      pre_nxt = pre_cnt + 1'b1;
    end
    // Disabled or forced: timebase restarts from zero, counting up.
    if (force_wr || !en_nxt) begin
      pre_nxt = '0;
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end
  end

  // A force write supersedes a coincident boundary.
  assign boundary = bnd_raw && !force_wr;
  assign update   = boundary || force_wr || en_rise;

  // Per-channel compare
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = cnt < duty_act[i];
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (avs.avs_address)
      A_CTRL:     rdata = DATA_W'({ctrl_irq_en, ctrl_mode, ctrl_en});
      A_PRESCALE: rdata = DATA_W'(prescale);
      A_PERIOD:   rdata = DATA_W'(period_stg);
      A_POLARITY: rdata = DATA_W'(pol_stg);
      A_STATUS:   rdata = {16'(cnt), 15'b0, pend};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (avs.avs_address == ADDR_W'(A_DUTY0 + i)) rdata = DATA_W'(duty_stg[i]);
        end
      end
    endcase
  end

  // Register file, active set, timebase and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en          <= 1'b0;
      ctrl_mode        <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      prescale         <= '0;
      period_stg       <= '0;
      pol_stg          <= '0;
      duty_stg         <= '0;
      pend             <= 1'b0;
      period_act       <= '0;
      mode_act         <= 1'b0;
      pol_act          <= '0;
      duty_act         <= '0;
      pre_cnt          <= '0;
      cnt              <= '0;
      dir_down         <= 1'b0;
      pwm_out          <= '0;
      irq              <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      if (avs.avs_write) begin
        case (avs.avs_address)
          A_CTRL: begin
            ctrl_en     <= avs.avs_writedata[0];
            ctrl_mode   <= avs.avs_writedata[1];
            ctrl_irq_en <= avs.avs_writedata[2];
          end
          A_PRESCALE: prescale   <= avs.avs_writedata[PRE_W-1:0];
          A_PERIOD:   period_stg <= avs.avs_writedata[CNT_W-1:0];
          A_POLARITY: pol_stg    <= avs.avs_writedata[NUM_CH-1:0];
          default: begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (avs.avs_address == ADDR_W'(A_DUTY0 + i)) begin
                duty_stg[i] <= avs.avs_writedata[CNT_W-1:0];
              end
            end
          end
        endcase
      end

      // Set wins over a coincident clear.
      if (boundary) begin
        pend <= 1'b1;
      end else if (w1c) begin
        pend <= 1'b0;
      end

      // Active set takes the pre-edge staging values.
      if (update) begin
        period_act <= period_stg;
        mode_act   <= ctrl_mode;
        pol_act    <= pol_stg;
        duty_act   <= duty_stg;
      end

      pre_cnt  <= pre_nxt;
      cnt      <= cnt_nxt;
      dir_down <= dir_nxt;

      pwm_out          <= ctrl_en ? (raw ^ pol_act) : pol_act;
      irq              <= pend & ctrl_irq_en;
      avs.avs_readdata <= avs.avs_read ? rdata : '0;
    end
  end

endmodule
